// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock's hour stage: repeater states,
// hour limits, display digit widths and the 24h/12h display conversion.
package relogio_pkg;

  localparam int unsigned UNI_W = 4;
  localparam int unsigned DEZ_W = 2;

  localparam logic [DEZ_W-1:0] HORA_MAX_DEZ  = 2'd2;
  localparam logic [UNI_W-1:0] HORA_MAX_UNI  = 4'd3;
  localparam logic [4:0]       HORA_MEIO_DIA = 5'd12;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    REPETE
  } estado_rep_t;

  typedef struct packed {
    logic [DEZ_W-1:0] dez;
    logic [UNI_W-1:0] uni;
    logic             pm;
  } display_t;

  // BCD hour (00-23) to display digits; 12h mode works digit-wise on BCD
  // so no binary-to-BCD division is needed.
  function automatic display_t converte_display(input logic [DEZ_W-1:0] dez,
                                                input logic [UNI_W-1:0] uni,
                                                input logic             modo_12h);
    display_t   d;
    logic [4:0] hora;
    hora = 5'(dez) * 5'd10 + 5'(uni);
    d.dez = dez;
    d.uni = uni;
    d.pm  = 1'b0;
    if (modo_12h) begin
      d.pm = (hora >= HORA_MEIO_DIA);
      if (hora == 5'd0) begin
        d.dez = 2'd1;
        d.uni = 4'd2;
      end else if (hora > HORA_MEIO_DIA) begin
        if (dez == 2'd1) begin
          d.dez = 2'd0;
          d.uni = uni - 4'd2;
        end else if (uni < 4'd2) begin
          d.dez = 2'd0;
          d.uni = uni + 4'd8;
        end else begin
          d.dez = 2'd1;
          d.uni = uni - 4'd2;
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/repetidor_botao.sv
// Push-button auto-repeat: one pulse on press, a second after REPEAT_DELAY
// cycles of holding, then one every REPEAT_PERIOD cycles.
module repetidor_botao
  import relogio_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 4,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ativo,
  input  logic botao,
  output logic pulso
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CARGA_ESPERA = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CARGA_REPETE = CW'(REPEAT_PERIOD - 1);

  estado_rep_t   estado, estado_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= OCIOSO;
      cnt    <= '0;
    end else begin
      estado <= estado_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    pulso      = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (ativo && botao) begin
          pulso      = 1'b1;
          cnt_nxt    = CARGA_ESPERA;
          estado_nxt = ESPERA;
        end
      end
      ESPERA: begin
        if (!ativo || !botao) begin
          estado_nxt = OCIOSO;
          cnt_nxt    = '0;
        end else if (cnt == '0) begin
          pulso      = 1'b1;
          cnt_nxt    = CARGA_REPETE;
          estado_nxt = REPETE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      REPETE: begin
        if (!ativo || !botao) begin
          estado_nxt = OCIOSO;
          cnt_nxt    = '0;
        end else if (cnt == '0) begin
          pulso   = 1'b1;
          cnt_nxt = CARGA_REPETE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        estado_nxt = OCIOSO;
        cnt_nxt    = '0;
      end
    endcase
  end

endmodule

// File: rtl/contador_horas.sv
// Hour stage of the digital clock: BCD 00-23 counter driven by the minute
// carry or by the adjust button, with registered 24h/12h display digits.
module contador_horas
  import relogio_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 4,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             carry_in,
  input  logic             ajuste,
  input  logic             botao_inc,
  input  logic             modo_12h,
  output logic [UNI_W-1:0] unidade,
  output logic [DEZ_W-1:0] dezena,
  output logic             pm,
  output logic             carry_out
);

  logic [UNI_W-1:0] h_uni, h_uni_nxt;
  logic [DEZ_W-1:0] h_dez, h_dez_nxt;
  logic             inc_man;
  logic             inc_cnt;
  logic             inc;
  logic             hora_max;
  display_t         disp_nxt;

  repetidor_botao #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repetidor (
    .clk   (clk),
    .rst   (rst),
    .ativo (ajuste),
    .botao (botao_inc),
    .pulso (inc_man)
  );

  // Minute carries are dropped (not deferred) while adjusting.
  assign inc_cnt  = !ajuste && enable && carry_in;
  assign inc      = inc_cnt || inc_man;
  assign hora_max = (h_dez == HORA_MAX_DEZ) && (h_uni == HORA_MAX_UNI);

  always_comb begin
    h_uni_nxt = h_uni;
    h_dez_nxt = h_dez;
    if (inc) begin
      if (hora_max) begin
        h_uni_nxt = '0;
        h_dez_nxt = '0;
      end else if (h_uni == 4'd9) begin
        h_uni_nxt = '0;
        h_dez_nxt = h_dez + 2'd1;
      end else begin
        h_uni_nxt = h_uni + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_uni     <= '0;
      h_dez     <= '0;
      carry_out <= 1'b0;
    end else begin
      h_uni     <= h_uni_nxt;
      h_dez     <= h_dez_nxt;
      carry_out <= inc_cnt && hora_max;
    end
  end

  assign disp_nxt = converte_display(h_dez, h_uni, modo_12h);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unidade <= '0;
      dezena  <= '0;
      pm      <= 1'b0;
    end else begin
      unidade <= disp_nxt.uni;
      dezena  <= disp_nxt.dez;
      pm      <= disp_nxt.pm;
    end
  end

endmodule

// File: tb/tb_contador_horas.sv
// Bench for contador_horas: integer-hour reference model checked every cycle,
// plus directed scenarios with hand-computed display values.
module tb_contador_horas;

  localparam int unsigned D = 4;
  localparam int unsigned P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       carry_in = 1'b0;
  logic       ajuste = 1'b0;
  logic       botao_inc = 1'b0;
  logic       modo_12h = 1'b0;
  logic [3:0] unidade;
  logic [1:0] dezena;
  logic       pm;
  logic       carry_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  contador_horas #(
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .carry_in  (carry_in),
    .ajuste    (ajuste),
    .botao_inc (botao_inc),
    .modo_12h  (modo_12h),
    .unidade   (unidade),
    .dezena    (dezena),
    .pm        (pm),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Reference model: hour as a plain integer, repeat timing from hold length.
  int hour_m   = 0;
  int k_held   = 0;
  int exp_uni  = 0;
  int exp_dez  = 0;
  int exp_pm   = 0;
  int exp_cout = 0;

  function automatic int shown(input int h, input bit m);
    if (!m) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  function automatic bit man_inc(input bit held, input int k);
    return held && (k == 0 || (k >= int'(D) && (k - int'(D)) % int'(P) == 0));
  endfunction

  function automatic int next_hour(input int h, input bit i);
    return i ? (h + 1) % 24 : h;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_m   <= 0;
      k_held   <= 0;
      exp_uni  <= 0;
      exp_dez  <= 0;
      exp_pm   <= 0;
      exp_cout <= 0;
    end else begin
      exp_uni  <= shown(hour_m, modo_12h) % 10;
      exp_dez  <= shown(hour_m, modo_12h) / 10;
      exp_pm   <= (modo_12h && hour_m >= 12) ? 1 : 0;
      exp_cout <= (!ajuste && enable && carry_in && hour_m == 23) ? 1 : 0;
      hour_m   <= next_hour(hour_m, (!ajuste && enable && carry_in) ||
                                    man_inc(ajuste && botao_inc, k_held));
      k_held   <= (ajuste && botao_inc) ? k_held + 1 : 0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_carry_out", int'(carry_out), exp_cout);
      chk("model_unidade",   int'(unidade),   exp_uni);
      chk("model_dezena",    int'(dezena),    exp_dez);
      chk("model_pm",        int'(pm),        exp_pm);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_carry(input int n);
    for (int i = 0; i < n; i++) begin
      carry_in = 1'b1;
      step(1);
    end
    carry_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  int tgt   [6] = '{0, 1, 11, 12, 13, 23};
  int t_uni [6] = '{2, 1, 1, 2, 1, 1};
  int t_dez [6] = '{1, 0, 1, 1, 0, 1};
  int t_pm  [6] = '{0, 0, 0, 1, 1, 1};
  int cur;

  initial begin
    #1 rst = 1'b0;
    step(2);
    rst = 1'b1;
    started = 1'b1;
    step(1);
    chk("reset_unidade", int'(unidade), 0);
    chk("reset_dezena",  int'(dezena),  0);
    chk("reset_pm",      int'(pm),      0);
    chk("reset_cout",    int'(carry_out), 0);

    // Counting: 09 -> 10 without carry, then 23 -> 00 with carry.
    enable = 1'b1;
    pulse_carry(9);
    step(1);
    chk("h09_disp", int'(dezena) * 10 + int'(unidade), 9);
    pulse_carry(1);
    chk("h09_to10_cout", int'(carry_out), 0);
    step(1);
    chk("h10_disp", int'(dezena) * 10 + int'(unidade), 10);
    pulse_carry(13);
    step(1);
    chk("h23_disp", int'(dezena) * 10 + int'(unidade), 23);
    pulse_carry(1);
    chk("wrap_cout", int'(carry_out), 1);
    chk("wrap_disp_lag", int'(dezena) * 10 + int'(unidade), 23);
    step(1);
    chk("wrap_cout_1cyc", int'(carry_out), 0);
    chk("wrap_disp", int'(dezena) * 10 + int'(unidade), 0);

    // Carries ignored when disabled or adjusting.
    enable = 1'b0;
    pulse_carry(3);
    enable = 1'b1;
    ajuste = 1'b1;
    pulse_carry(3);
    ajuste = 1'b0;
    step(2);
    chk("ignored_disp", int'(dezena) * 10 + int'(unidade), 0);

    // Auto-repeat from 22 across the manual wrap.
    do_reset();
    pulse_carry(22);
    ajuste = 1'b1;
    botao_inc = 1'b1;
    step(11);
    botao_inc = 1'b0;
    step(3);
    chk("repeat_disp", int'(dezena) * 10 + int'(unidade), 3);
    ajuste = 1'b0;

    // 12h sweep with a 24h toggle at 13.
    do_reset();
    modo_12h = 1'b1;
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      pulse_carry(tgt[i] - cur);
      step(1);
      chk("h12_unidade", int'(unidade), t_uni[i]);
      chk("h12_dezena",  int'(dezena),  t_dez[i]);
      chk("h12_pm",      int'(pm),      t_pm[i]);
      if (tgt[i] == 13) begin
        modo_12h = 1'b0;
        step(1);
        chk("toggle24_disp", int'(dezena) * 10 + int'(unidade), 13);
        chk("toggle24_pm",   int'(pm), 0);
        modo_12h = 1'b1;
        step(1);
      end
      cur = tgt[i];
    end
    modo_12h = 1'b0;

    // ajuste dropped mid-repeat, then re-raised with the button still held.
    do_reset();
    ajuste = 1'b1;
    botao_inc = 1'b1;
    step(7);
    ajuste = 1'b0;
    step(4);
    chk("drop_adjust_disp", int'(dezena) * 10 + int'(unidade), 3);
    ajuste = 1'b1;
    step(2);
    chk("reraise_disp", int'(dezena) * 10 + int'(unidade), 4);
    ajuste = 1'b0;
    botao_inc = 1'b0;

    // Asynchronous reset while waiting for repeat at hour 17.
    do_reset();
    pulse_carry(16);
    ajuste = 1'b1;
    botao_inc = 1'b1;
    step(2);
    chk("pre_rst_disp", int'(dezena) * 10 + int'(unidade), 17);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_unidade", int'(unidade), 0);
    chk("async_rst_dezena",  int'(dezena),  0);
    chk("async_rst_pm",      int'(pm),      0);
    chk("async_rst_cout",    int'(carry_out), 0);
    @(negedge clk);
    #1;
    ajuste = 1'b0;
    botao_inc = 1'b0;
    rst = 1'b1;
    step(1);
    pulse_carry(1);
    step(1);
    chk("post_rst_disp", int'(dezena) * 10 + int'(unidade), 1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
